datapath_sequencer: RTL

- Multi-cycle control FSM that sequences the ALU/register-bank datapath: fetches 16-bit instructions over a request/valid handshake, decodes them, and drives register-select, immediate-mux, ALU op, bus-enable and register write-enable lines.
- Holds the PC and the architectural flags register; resolves conditional branches.
- Sits between instruction memory and the ALU/register datapath; sole owner of those datapath control inputs.

---
 rtl/datapath_sequencer_pkg.sv | 57 +++++
 rtl/datapath_sequencer_cond_eval.sv | 37 +++
 rtl/datapath_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/datapath_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : datapath_sequencer_pkg
//  Purpose  : Shared definitions for the datapath sequencer: FSM state
//             encoding, opcode / opext values, branch condition codes,
//             flag bit positions and the HALT instruction word.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package datapath_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    // Major opcodes
    localparam logic [3:0] OPC_REG      = 4'h0;
    localparam logic [3:0] OPC_IMM_LAST = 4'hB;
    localparam logic [3:0] OPC_BCOND    = 4'hC;

    // ALU operation codes (opext for register ops, opcode for immediates)
    localparam logic [3:0] OPX_ADDC = 4'h7;
    localparam logic [3:0] OPX_SUBC = 4'hA;
    localparam logic [3:0] OPX_CMP  = 4'hB;

    // Branch condition codes
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_GT = 4'h4;
    localparam logic [3:0] COND_LE = 4'h5;
    localparam logic [3:0] COND_FS = 4'h6;
    localparam logic [3:0] COND_FC = 4'h7;
    localparam logic [3:0] COND_LO = 4'h8;
    localparam logic [3:0] COND_HS = 4'h9;
    localparam logic [3:0] COND_AL = 4'hE;

    // Bit positions inside the {C,L,F,Z,N} flag vector
    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 3;
    localparam int FLAG_C = 4;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/datapath_sequencer_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module   : datapath_sequencer_cond_eval
//  Purpose  : Combinational branch-condition evaluator.
//  Ports    : i_cond  [3:0]  condition code
//             i_flags [4:0]  architectural flags {C,L,F,Z,N}
//             o_taken        condition holds
//  Revision : 1.0  initial release
// ============================================================================
module datapath_sequencer_cond_eval
    import datapath_sequencer_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [4:0] i_flags,
    output logic       o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            COND_EQ: o_taken =  i_flags[FLAG_Z];
            COND_NE: o_taken = ~i_flags[FLAG_Z];
            COND_CS: o_taken =  i_flags[FLAG_C];
            COND_CC: o_taken = ~i_flags[FLAG_C];
            COND_GT: o_taken =  i_flags[FLAG_N];
            COND_LE: o_taken = ~i_flags[FLAG_N];
            COND_FS: o_taken =  i_flags[FLAG_F];
            COND_FC: o_taken = ~i_flags[FLAG_F];
            COND_LO: o_taken =  i_flags[FLAG_L];
            COND_HS: o_taken = ~i_flags[FLAG_L];
            COND_AL: o_taken =  1'b1;
            default: o_taken =  1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/datapath_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : datapath_sequencer
//  Purpose  : Multi-cycle FETCH/WAIT/DECODE/EXEC control FSM for the
//             ALU/register-bank datapath. Owns PC and flags, resolves Bcond.
//  Ports    : clk, Reset (sync, active high)
//             imem_req/imem_addr/imem_valid/imem_rdata : instruction fetch
//             alu_flags                                : ALU flag results
//             A_Mux_input, B_Mux_input, Imm_mux_input, Immediate, OP, cin :
//                 registered datapath controls, stable DECODE..EXEC
//             Tri_Enable, Reg_Enable : write-back strobes, EXEC only
//             halted, pc             : status
//  Revision : 1.0  initial release
// ============================================================================
module datapath_sequencer
    import datapath_sequencer_pkg::*;
#(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
)
(
    input  logic                clk,
    input  logic                Reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_valid,
    input  logic [15:0]         imem_rdata,
    input  logic [4:0]          alu_flags,
    output logic [3:0]          A_Mux_input,
    output logic [3:0]          B_Mux_input,
    output logic                Imm_mux_input,
    output logic [15:0]         Immediate,
    output logic [7:0]          OP,
    output logic                cin,
    output logic                Tri_Enable,
    output logic [15:0]         Reg_Enable,
    output logic                halted,
    output logic [PC_WIDTH-1:0] pc
);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [4:0]          flags_q, flags_d;
    logic [3:0]          a_sel_q, a_sel_d, b_sel_q, b_sel_d;
    logic                imm_sel_q, imm_sel_d;
    logic [15:0]         imm_q, imm_d;
    logic [7:0]          op_q, op_d;
    logic                cin_q, cin_d;

    // Decode of the word arriving from memory; controls are loaded together
    // with IR so they are already valid during the DECODE cycle.
    logic [3:0] w_in_opc, w_in_ext, w_in_kind;
    logic       w_in_reg, w_in_imm;
    assign w_in_opc  = imem_rdata[15:12];
    assign w_in_ext  = imem_rdata[7:4];
    assign w_in_reg  = (w_in_opc == OPC_REG);
    assign w_in_imm  = (w_in_opc != OPC_REG) && (w_in_opc <= OPC_IMM_LAST);
    assign w_in_kind = w_in_imm ? w_in_opc : w_in_ext;

    // Decode of the latched instruction, used in EXEC
    logic [3:0]          w_ir_opc;
    logic                w_ir_alu, w_ir_cmp, w_ir_halt, w_ir_bcond, w_taken;
    logic                w_exec_alu;
    logic [PC_WIDTH-1:0] w_disp, w_pc_inc;
    assign w_ir_opc   = ir_q[15:12];
    assign w_ir_alu   = (w_ir_opc <= OPC_IMM_LAST);
    assign w_ir_cmp   = (w_ir_opc == OPX_CMP) ||
                        ((w_ir_opc == OPC_REG) && (ir_q[7:4] == OPX_CMP));
    assign w_ir_halt  = (ir_q == HALT_WORD);
    assign w_ir_bcond = (w_ir_opc == OPC_BCOND);
    assign w_disp     = {{(PC_WIDTH-8){ir_q[7]}}, ir_q[7:0]};
    assign w_pc_inc   = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    assign w_exec_alu = (state_q == ST_EXEC) && w_ir_alu;

    datapath_sequencer_cond_eval u_cond_eval (
        .i_cond  (ir_q[11:8]),
        .i_flags (flags_q),
        .o_taken (w_taken)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        flags_d   = flags_q;
        a_sel_d   = a_sel_q;
        b_sel_d   = b_sel_q;
        imm_sel_d = imm_sel_q;
        imm_d     = imm_q;
        op_d      = op_q;
        cin_d     = cin_q;
        case (state_q)
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (imem_valid) begin
                    ir_d      = imem_rdata;
                    a_sel_d   = imem_rdata[11:8];
                    b_sel_d   = imem_rdata[3:0];
                    imm_sel_d = w_in_imm;
                    imm_d     = sext8(imem_rdata[7:0]);
                    op_d      = w_in_reg ? {4'h0, w_in_ext} :
                                w_in_imm ? {w_in_opc, 4'h0} : 8'h00;
                    // Flags only change at the end of EXEC, so the value
                    // seen here is the one the instruction executes with.
                    cin_d     = (w_in_reg || w_in_imm) &&
                                ((w_in_kind == OPX_ADDC) || (w_in_kind == OPX_SUBC)) &&
                                flags_q[FLAG_C];
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (w_ir_halt) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_FETCH;
                    pc_d    = (w_ir_bcond && w_taken) ? (pc_q + w_disp) : w_pc_inc;
                    if (w_ir_alu) begin
                        flags_d = alu_flags;
                    end
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            flags_q   <= '0;
            a_sel_q   <= '0;
            b_sel_q   <= '0;
            imm_sel_q <= 1'b0;
            imm_q     <= '0;
            op_q      <= '0;
            cin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            flags_q   <= flags_d;
            a_sel_q   <= a_sel_d;
            b_sel_q   <= b_sel_d;
            imm_sel_q <= imm_sel_d;
            imm_q     <= imm_d;
            op_q      <= op_d;
            cin_q     <= cin_d;
        end
    end

    assign imem_req      = (state_q == ST_FETCH) || (state_q == ST_WAIT);
    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign halted        = (state_q == ST_HALTED);
    assign A_Mux_input   = a_sel_q;
    assign B_Mux_input   = b_sel_q;
    assign Imm_mux_input = imm_sel_q;
    assign Immediate     = imm_q;
    assign OP            = op_q;
    assign cin           = cin_q;
    assign Tri_Enable    = w_exec_alu;
    // CMP drives the bus for flag generation but never commits a register
    assign Reg_Enable    = (w_exec_alu && !w_ir_cmp) ? (16'h0001 << ir_q[11:8]) : 16'h0000;

endmodule
`default_nettype wire
